// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed scan controller for a multi-digit
// 7-segment display with a frame-coherent shadow of the digit nibbles.
// Ports: clk, rst (async, active-high), upd strobe + data_in nibbles,
// lz_en (leading-zero blanking), upd_ack and frame_start pulses,
// dig_sel (active-low digit enables), nib_out (code to the decoder).
// Optional: SCAN_BLINK_EN adds blink_mask and an 8-bit frame counter.
module led_scan_ctrl #(
  parameter int DIGITS  = 8,
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  upd,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  lz_en,
`ifdef SCAN_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  upd_ack,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     dig_sel,
  output logic [3:0]            nib_out
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_GRD = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
  localparam logic [3:0]    BLANK   = 4'hA;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic                pending;
  logic [4*DIGITS-1:0] pend_data;
  logic [4*DIGITS-1:0] shadow;

  logic                tick;
  logic                boundary;
  logic                commit;
  logic [DIGITS-1:0]   sel_n;
  logic [DIGITS-1:0]   zfrom;
  logic                run;
  logic                sup;
  logic [3:0]          cur;
  logic [3:0]          code;

`ifdef SCAN_BLINK_EN
  logic [7:0]          fcnt;
`endif

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == IDX_MAX);
  assign commit   = boundary && (pending || upd);

  always_comb begin
    sel_n = ~(DIGITS'(1) << idx);
  end

  // zfrom[i]: nibbles i..DIGITS-1 of the shadow are all zero
  always_comb begin
    run   = 1'b1;
    zfrom = '0;
    cur   = BLANK;
    sup   = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run      = run & (shadow[4*i +: 4] == 4'h0);
      zfrom[i] = run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur = shadow[4*i +: 4];
        sup = (i != 0) && zfrom[i];
      end
    end
    code = cur;
`ifdef SCAN_BLINK_EN
    if (fcnt[7] && blink_mask[idx]) code = BLANK;
`endif
    if (lz_en && sup) code = BLANK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      pend_data   <= '0;
      shadow      <= {DIGITS{BLANK}};
      upd_ack     <= 1'b0;
      frame_start <= 1'b0;
      dig_sel     <= '1;
      nib_out     <= BLANK;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);

      if (upd) pend_data <= data_in;
      // a strobe landing on the boundary bypasses the pending copy
      if (commit) begin
        shadow  <= upd ? data_in : pend_data;
        pending <= 1'b0;
      end else if (upd) begin
        pending <= 1'b1;
      end

      upd_ack     <= commit;
      frame_start <= boundary;

      if (cnt >= CNT_GRD) begin
        dig_sel <= sel_n;
        nib_out <= code;
      end else begin
        dig_sel <= '1;
        nib_out <= BLANK;
      end
    end
  end

`ifdef SCAN_BLINK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fcnt <= '0;
    else if (boundary) fcnt <= fcnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb_led_scan_ctrl: scoreboard bench for led_scan_ctrl
// (DIGITS=4, CLK_DIV=8, GUARD=2).
module tb_led_scan_ctrl;

  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 8;
  localparam int GUARD   = 2;

`ifdef SCAN_BLINK_EN
  localparam int KMAX = 130;
  logic [3:0] blink_mask = 4'b0001;
`else
  localparam int KMAX = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        upd = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        upd_ack;
  logic        frame_start;
  logic [3:0]  dig_sel;
  logic [3:0]  nib_out;

  led_scan_ctrl #(
    .DIGITS (DIGITS),
    .CLK_DIV(CLK_DIV),
    .GUARD  (GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd),
    .data_in    (data_in),
    .lz_en      (lz_en),
`ifdef SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .upd_ack    (upd_ack),
    .frame_start(frame_start),
    .dig_sel    (dig_sel),
    .nib_out    (nib_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] nib;
  } slot_t;

  slot_t slotq[$];
  bit    ackq[$];
  slot_t e;
  int    n_chk = 0;
  int    n_pass = 0;
  bit    mon_en = 1'b1;
  int    cyc = 0;
  int    last_fs = -1;
  int    nb = 0;
  logic [3:0] prev_sel = 4'hF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // monitor: one expected entry per active window, one ack flag per boundary
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (dig_sel != 4'hF && prev_sel == 4'hF) begin
        if (slotq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected slot: got sel %b, want none", dig_sel);
        end else begin
          e = slotq.pop_front();
          chk("slot dig_sel", 32'(dig_sel), 32'(e.sel));
          chk("slot nib_out", 32'(nib_out), 32'(e.nib));
        end
      end
      if (frame_start) begin
        if (ackq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected boundary: got frame_start 1, want 0");
        end else begin
          chk("upd_ack at boundary", 32'(upd_ack), 32'(ackq.pop_front()));
        end
      end else if (upd_ack) begin
        n_chk++;
        $display("FAIL stray upd_ack: got 1, want 0");
      end
    end
    prev_sel = dig_sel;
  end

  task automatic push_frame(input logic [15:0] codes);
    slot_t s;
    for (int i = 0; i < 4; i++) begin
      s.sel = ~(4'b0001 << i);
      s.nib = codes[4*i +: 4];
      slotq.push_back(s);
    end
  endtask

  task automatic push_ack(input bit a);
    ackq.push_back(a);
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_upd(input logic [15:0] d);
    data_in = d;
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
  endtask

  task automatic wait_frame();
    int w;
    w = 0;
    while (!frame_start && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!frame_start) begin
      n_chk++;
      $display("FAIL frame_start timeout: got none in 40 cycles, want pulse");
    end else begin
      nb++;
      if (last_fs >= 0) chk("frame period", 32'(cyc - last_fs), 32'd32);
      last_fs = cyc;
    end
  endtask

  initial begin
    steps(3);
    chk("reset dig_sel", 32'(dig_sel), 32'hF);
    chk("reset nib_out", 32'(nib_out), 32'hA);
    chk("reset upd_ack", 32'(upd_ack), 32'h0);
    chk("reset frame_start", 32'(frame_start), 32'h0);

    // F0: blank shadow; 1234 arrives mid-frame
    push_frame(16'hAAAA);
    push_ack(1'b1);
    rst = 1'b0;
    steps(1);
    chk("guard cyc1 dig_sel", 32'(dig_sel), 32'hF);
    steps(1);
    chk("guard cyc2 dig_sel", 32'(dig_sel), 32'hF);
    steps(1);
    chk("first slot dig_sel", 32'(dig_sel), 32'hE);
    chk("first slot nib_out", 32'(nib_out), 32'hA);
    steps(4);
    pulse_upd(16'h1234);
    wait_frame();

    // F1: shows 4,3,2,1; two updates, latest wins
    push_frame(16'h1234);
    push_ack(1'b1);
    steps(5);
    pulse_upd(16'h1111);
    steps(10);
    pulse_upd(16'h5678);
    wait_frame();

    // F2: 1111 pending, 9999 on the boundary tick cycle
    push_frame(16'h5678);
    push_ack(1'b1);
    steps(5);
    pulse_upd(16'h1111);
    steps(25);
    pulse_upd(16'h9999);
    wait_frame();

    // F3: 9999, lz on (no effect), load 0070
    lz_en = 1'b1;
    push_frame(16'h9999);
    push_ack(1'b1);
    steps(5);
    pulse_upd(16'h0070);
    wait_frame();

    // F4: 0070 with lz -> 0,7,A,A; load 0000
    push_frame(16'hAA70);
    push_ack(1'b1);
    steps(5);
    pulse_upd(16'h0000);
    wait_frame();

    // F5: 0000 with lz -> 0,A,A,A
    push_frame(16'hAAA0);
    push_ack(1'b0);
    steps(2);
    wait_frame();

    // F6: lz off -> 0,0,0,0; leave 4444 pending, reset in slot 3
    lz_en = 1'b0;
    push_frame(16'h0000);
    push_ack(1'b0);
    steps(5);
    pulse_upd(16'h4444);
    steps(23);
    chk("pre-reset dig_sel", 32'(dig_sel), 32'h7);
    rst = 1'b1;
    #1;
    chk("mid-slot reset dig_sel", 32'(dig_sel), 32'hF);
    chk("mid-slot reset nib_out", 32'(nib_out), 32'hA);
    chk("mid-slot reset upd_ack", 32'(upd_ack), 32'h0);
    chk("mid-slot reset frame_start", 32'(frame_start), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    last_fs = -1;

    // P0: blank, pending 4444 lost (F6 ack flag 0 checks this boundary)
    push_frame(16'hAAAA);
    steps(2);
    wait_frame();

    // P1: load 1234
    push_frame(16'hAAAA);
    push_ack(1'b1);
    steps(5);
    pulse_upd(16'h1234);
    wait_frame();

    for (int k = 2; k <= KMAX; k++) begin
      push_frame((k >= 128) ? 16'h123A : 16'h1234);
      if (k < KMAX) begin
        push_ack(1'b0);
        steps(2);
        wait_frame();
      end
    end

    steps(30);
    mon_en = 1'b0;
    chk("slot queue drained", 32'(slotq.size()), 32'd0);
    chk("ack queue drained", 32'(ackq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Time-multiplexed scan controller for the timer's multi-digit 7-segment display.
- Holds a frame-coherent shadow copy of all digit nibbles and steps through the digits at a divided scan rate.
- Drives one-cold (active-low) digit enables, plus the 4-bit code fed to the shared combinational 7-segment decoder.
- Decoder code convention: 0-9 are numerals, 4'hA is blank (all segments off), 4'hB-4'hF show a dash.

Parameters:
- DIGITS, 8, number of scanned digits (2..8).
- CLK_DIV, 50000, clk cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at the start of each slot with all digits disabled (anti-ghosting).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- upd  in  1  one-cycle strobe: new display data valid.
- data_in  in  4*DIGITS  packed nibbles; digit i = data_in[4i+3:4i]; digit 0 is rightmost/LSD.
- lz_en  in  1  leading-zero suppression enable, sampled every cycle.
- upd_ack  out  1  one-cycle pulse when pending data is committed to the shadow.
- frame_start  out  1  one-cycle pulse on the clock after the slot counter wraps to digit 0.
- dig_sel  out  DIGITS  active-low digit enables; at most one bit low.
- nib_out  out  4  code to the 7-segment decoder.

Behaviour:
- Reset (async, active-high) values:
  - prescaler = 0, idx = 0, pending = 0.
  - shadow = all 4'hA.
  - dig_sel = all ones, nib_out = 4'hA.
  - upd_ack = 0, frame_start = 0.
- Prescaler counts 0..CLK_DIV-1 and wraps. The tick is asserted at count CLK_DIV-1.
- On tick, idx advances by 1, wrapping DIGITS-1 -> 0. Wrap to 0 is the frame boundary.
- Slot timing, with cnt = prescaler value:
  - cnt 0..GUARD-1: dig_sel all ones, nib_out = 4'hA.
  - cnt GUARD..CLK_DIV-1: dig_sel[idx] = 0, all other bits 1; nib_out = code(idx).
  - All outputs are registered; they change one clk after the prescaler value that selects them.
- Update handshake:
  - upd copies data_in into pend_data and sets pending. A second upd before commit overwrites pend_data (latest wins).
  - Commit happens on the frame-boundary tick if pending or upd is set.
  - If upd is set in the same cycle as the boundary, shadow takes data_in directly; otherwise shadow takes pend_data.
  - Commit clears pending and pulses upd_ack for 1 cycle. The shadow never changes mid-frame, so there is no tearing.
- code(i):
  - Start from shadow nibble i.
  - If lz_en = 1 and i >= 1 and shadow nibbles i..DIGITS-1 are all 4'h0, the result is 4'hA.
  - Digit 0 is never suppressed. Nibbles 4'hA-4'hF pass through unchanged.
- Reset mid-slot or mid-frame returns immediately to the reset state. Pending data is lost and no upd_ack is issued.
- Nothing stalls scanning: upd is always accepted, with no backpressure.

Optional Feature:
- Macro: SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask (DIGITS bits) and an 8-bit frame counter (reset 0) that increments on each frame boundary.
  - While frame counter bit 7 = 1, digits whose blink_mask bit is set output 4'hA during their active window.
  - dig_sel still asserts for those digits.
  - blink_mask is applied before leading-zero suppression, in addition to it.
- Undefined: no blink_mask port, no frame counter, and code() is as above.

Test Plan (DIGITS=4, CLK_DIV=8, GUARD=2 unless noted):
- Reset held, then released -> dig_sel=4'b1111 and nib_out=4'hA until cycle 3. Then dig_sel=4'b1110 with nib_out=4'hA (blank shadow). Slot period is 8 clks; frame_start has a period of 32 clks.
- upd with data_in=16'h1234 mid-frame -> no change until the frame boundary. Then one upd_ack pulse, and slots show 4,3,2,1 with dig_sel 1110,1101,1011,0111.
- Two upds (16'h1111, then 16'h5678) in the same frame -> exactly one upd_ack, and the display shows 8,7,6,5.
- upd asserted on the exact boundary-tick cycle with data_in=16'h9999 while 16'h1111 is pending -> 16'h9999 is committed.
- lz_en=1, shadow=16'h0070 -> codes for digits 0..3 are 0,7,A,A. With shadow=16'h0000 -> 0,A,A,A. With lz_en=0 -> 0,0,0,0.
- rst pulsed mid-slot while pending=1 -> outputs return to reset values within the reset cycle, and no upd_ack follows. With SCAN_BLINK_EN and blink_mask=4'b0001, digit 0 shows 4'hA during frames 128..255.
